// File: rtl/mem_model_pkg.sv
// rtl/mem_model_pkg.sv - shared types, constants and helpers for the memory responder model
//
// Purpose: common definitions used by mem_resp_model and mem_model_fifo.
//   DELAY_W      width of the free delay inputs and of every countdown
//   GNT_MAX_DEF  default ceiling on request-to-grant delay
//   RV_MAX_DEF   default ceiling on grant-to-rvalid delay
//   MEM_IDX_W    width of the stored word index (backing stores up to 2**MEM_IDX_W words)
//   gnt_state_e  grant FSM states
//   entry_t      one outstanding request: write flag, word index, cycles left to respond
//   clamp()      saturate a delay value into [lo, hi]

package mem_model_pkg;

    localparam int DELAY_W     = 3;
    localparam int GNT_MAX_DEF = 5;
    localparam int RV_MAX_DEF  = 5;
    localparam int MEM_IDX_W   = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } gnt_state_e;

    typedef struct packed {
        logic                 we;
        logic [MEM_IDX_W-1:0] idx;
        logic [DELAY_W-1:0]   rv_cnt;
    } entry_t;

    function automatic logic [DELAY_W-1:0] clamp(
        input logic [DELAY_W-1:0] val,
        input logic [DELAY_W-1:0] lo,
        input logic [DELAY_W-1:0] hi
    );
        logic [DELAY_W-1:0] res;
        res = val;
        if (res < lo) res = lo;
        if (res > hi) res = hi;
        return res;
    endfunction

endpackage

// File: rtl/mem_model_fifo.sv
// rtl/mem_model_fifo.sv - in-order outstanding-request queue with per-entry response countdown
//
// Purpose: holds granted requests until their response cycle. Every stored entry
// counts its rv_cnt down to 0 and holds there; only the head may respond, so
// responses stay in order and at most one leaves per cycle.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset (empties the queue)
//   push_i              store push_entry_i at the tail this cycle
//   push_entry_i        entry to store; rv_cnt = cycles left after the push cycle
//   pop_i               remove the head this cycle
//   push_ready_o        a push is accepted (not full, or full with a pop this cycle)
//   head_valid_o        head present and its countdown has expired
//   head_entry_o        current head entry
//   count_o             registered number of stored entries

module mem_model_fifo
    import mem_model_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  entry_t                     push_entry_i,
    input  logic                       pop_i,
    output logic                       push_ready_o,
    output logic                       head_valid_o,
    output entry_t                     head_entry_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    entry_t          entries_q [DEPTH];
    entry_t          entries_d [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    // A full queue still accepts a push when the head leaves in the same cycle:
    // the freed slot is the one the tail points at.
    assign push_ready_o = (count_q != CW'(DEPTH)) || pop_i;
    assign head_valid_o = (count_q != '0) && (entries_q[head_q].rv_cnt == '0);
    assign head_entry_o = entries_q[head_q];
    assign count_o      = count_q;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = entries_q[i];
            // Free-running countdown on every slot; empty slots are never read
            // as valid, so decrementing them is harmless.
            if (entries_q[i].rv_cnt != '0) begin
                entries_d[i].rv_cnt = entries_q[i].rv_cnt - DELAY_W'(1);
            end
        end
        if (push_i) begin
            entries_d[tail_q] = push_entry_i;
        end

        head_d  = pop_i  ? head_q + PW'(1) : head_q;
        tail_d  = push_i ? tail_q + PW'(1) : tail_q;

        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload carries no reset: slots outside [head, head+count) are don't-care.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            entries_q[i] <= entries_d[i];
        end
    end

endmodule

// File: rtl/mem_resp_model.sv
// rtl/mem_resp_model.sv - bounded-latency memory responder for the core req/gnt/rvalid interface
//
// Purpose: slave model of an instruction/data memory port. Grant and response
// timing come from the free inputs gnt_delay_i / rv_delay_i (clamped), so a
// formal tool explores every legal timing while the protocol holds by construction.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   req_i, addr_i     core request and byte address (word index = addr_i[IW+1:2])
//   we_i, be_i        write enable and byte enables
//   wdata_i           write data, committed to the store at the grant edge
//   gnt_delay_i       cycles from request to grant, clamped to GNT_MAX
//   rv_delay_i        cycles from grant to rvalid, sampled at grant, clamped to [1, RV_MAX]
//   gnt_o             grant (may be combinational in the request cycle)
//   rvalid_o          one-cycle response strobe, strictly in order
//   rdata_o           read data with rvalid_o, 0 for write responses
//   err_o             constant 0
//   outstanding_o     registered count of granted, not yet responded requests

module mem_resp_model
    import mem_model_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int DEPTH     = 4,
    parameter int GNT_MAX   = GNT_MAX_DEF,
    parameter int RV_MAX    = RV_MAX_DEF,
    parameter int MEM_WORDS = 256
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_i,
    input  logic [AW-1:0]              addr_i,
    input  logic                       we_i,
    input  logic [DW/8-1:0]            be_i,
    input  logic [DW-1:0]              wdata_i,
    input  logic [DELAY_W-1:0]         gnt_delay_i,
    input  logic [DELAY_W-1:0]         rv_delay_i,
    output logic                       gnt_o,
    output logic                       rvalid_o,
    output logic [DW-1:0]              rdata_o,
    output logic                       err_o,
    output logic [$clog2(DEPTH+1)-1:0] outstanding_o
);

    localparam int IW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [DELAY_W-1:0] GNT_MAX_L = DELAY_W'(GNT_MAX);
    localparam logic [DELAY_W-1:0] RV_MAX_L  = DELAY_W'(RV_MAX);

    gnt_state_e          state_q, state_d;
    logic [DELAY_W-1:0]  wcnt_q, wcnt_d;
    logic [DELAY_W-1:0]  gnt_lim;
    logic                gnt;
    logic                pop;
    logic                push_ready;
    logic                head_valid;
    entry_t              push_entry;
    entry_t              head_entry;
    logic [CW-1:0]       count;
    logic [IW-1:0]       req_idx;
    logic [DW-1:0]       mem_q [MEM_WORDS];
    logic                unused_bits;

    assign req_idx = addr_i[IW+1:2];
    assign gnt_lim = clamp(gnt_delay_i, '0, GNT_MAX_L);

    // Grant FSM. wcnt holds the cycles still to wait after the current one, so a
    // request with delay N sees gnt exactly N cycles after it first appears.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        gnt     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    if ((gnt_delay_i == '0) && push_ready) begin
                        gnt = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        wcnt_d  = (gnt_lim == '0) ? '0 : gnt_lim - DELAY_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - DELAY_W'(1);
                end else if (req_i && push_ready) begin
                    gnt     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (rst_i) begin
            gnt = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // The stored countdown excludes the grant cycle itself, so the minimum
    // response latency of one cycle is an rv_cnt of 0 at the first queued cycle.
    always_comb begin
        push_entry        = '0;
        push_entry.we     = we_i;
        push_entry.idx    = MEM_IDX_W'(req_idx);
        push_entry.rv_cnt = clamp(rv_delay_i, DELAY_W'(1), RV_MAX_L) - DELAY_W'(1);
    end

    assign pop = head_valid && !rst_i;

    mem_model_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push_i       (gnt),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .push_ready_o (push_ready),
        .head_valid_o (head_valid),
        .head_entry_o (head_entry),
        .count_o      (count)
    );

    // Backing store: contents survive reset. Writes land at the grant edge, so
    // any read granted later observes them.
    always_ff @(posedge clk_i) begin
        if (gnt && we_i) begin
            for (int b = 0; b < DW/8; b++) begin
                if (be_i[b]) begin
                    mem_q[req_idx][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        if (pop && !head_entry.we) begin
            rdata_o = mem_q[head_entry.idx[IW-1:0]];
        end
    end

    assign gnt_o         = gnt;
    assign rvalid_o      = pop;
    assign err_o         = 1'b0;
    assign outstanding_o = count;

    assign unused_bits = ^{addr_i[AW-1:IW+2], addr_i[1:0], head_entry.idx[MEM_IDX_W-1:IW]};

endmodule

// File: tb/tb_mem_resp_model.sv
// tb/tb_mem_resp_model.sv - self-checking bench for mem_resp_model

module tb_mem_resp_model;

    localparam int DEPTH = 4;

    logic        clk_i;
    logic        rst_i;
    logic        req_i;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic [2:0]  gnt_delay_i;
    logic [2:0]  rv_delay_i;
    logic        gnt_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic [2:0]  outstanding_o;

    mem_resp_model dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_i         (req_i),
        .addr_i        (addr_i),
        .we_i          (we_i),
        .be_i          (be_i),
        .wdata_i       (wdata_i),
        .gnt_delay_i   (gnt_delay_i),
        .rv_delay_i    (rv_delay_i),
        .gnt_o         (gnt_o),
        .rvalid_o      (rvalid_o),
        .rdata_o       (rdata_o),
        .err_o         (err_o),
        .outstanding_o (outstanding_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference model: responses owed, each with the earliest cycle it may appear.
    typedef struct {
        logic we;
        int   idx;
        int   ready;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mem_m [256];
    int          cyc;
    logic        in_req;
    int          req_start;
    int          req_lat;

    int n_cmp;
    int n_mis;

    logic        o_gnt;
    logic        o_rv;
    logic [31:0] o_rdata;
    logic [2:0]  o_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input logic r, input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] d, input logic [2:0] gd, input logic [2:0] rd,
                        input logic rs);
        logic        e_gnt;
        logic        e_rv;
        logic [31:0] e_rd;
        int          e_out;
        int          rl;
        int          ix;
        rst_i = rs; req_i = r; addr_i = a; we_i = w; be_i = b; wdata_i = d;
        gnt_delay_i = gd; rv_delay_i = rd;
        @(negedge clk_i);
        o_gnt = gnt_o; o_rv = rvalid_o; o_rdata = rdata_o; o_out = outstanding_o;

        e_gnt = 1'b0; e_rv = 1'b0; e_rd = '0; e_out = q.size();
        if (!rs) begin
            if (q.size() > 0 && q[0].ready <= cyc) begin
                e_rv = 1'b1;
                if (!q[0].we) e_rd = mem_m[q[0].idx];
            end
            if (r && !in_req) begin
                in_req    = 1'b1;
                req_start = cyc;
                req_lat   = (int'(gd) > 5) ? 5 : int'(gd);
            end
            if (r && cyc >= req_start + req_lat && (q.size() < DEPTH || e_rv)) e_gnt = 1'b1;
        end

        check("gnt", {31'b0, o_gnt}, {31'b0, e_gnt});
        check("rvalid", {31'b0, o_rv}, {31'b0, e_rv});
        check("rdata", o_rdata, e_rd);
        check("outstanding", {29'b0, o_out}, 32'(e_out));
        check("err", {31'b0, err_o}, 32'd0);

        if (rs) begin
            q.delete();
            in_req = 1'b0;
        end else begin
            if (e_rv) void'(q.pop_front());
            if (e_gnt) begin
                rl = (rd == 3'd0) ? 1 : ((int'(rd) > 5) ? 5 : int'(rd));
                ix = int'(a[9:2]);
                q.push_back('{we: w, idx: ix, ready: cyc + rl});
                if (w) begin
                    for (int k = 0; k < 4; k++) begin
                        if (b[k]) mem_m[ix][k*8 +: 8] = d[k*8 +: 8];
                    end
                end
                in_req = 1'b0;
            end
        end
        cyc++;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        step(1'b0, $urandom(), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom(),
             3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b0);
    endtask

    // Holds a request until granted; lat is the number of cycles from the first
    // request cycle to the grant cycle.
    task automatic txn(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d,
                       input logic [2:0] gd, input logic [2:0] rd, input logic jitter,
                       output int lat, output logic rv_at_gnt);
        logic [2:0] g;
        logic [2:0] v;
        lat = -1; rv_at_gnt = 1'b0;
        for (int k = 0; k < 40; k++) begin
            g = (jitter && k > 0) ? 3'($urandom_range(0, 7)) : gd;
            v = jitter ? 3'($urandom_range(0, 7)) : rd;
            step(1'b1, a, w, b, d, g, v, 1'b0);
            if (o_gnt) begin
                lat = k;
                rv_at_gnt = o_rv;
                return;
            end
        end
        check("gnt_timeout", {31'b0, o_gnt}, 32'd1);
        in_req = 1'b0;
    endtask

    task automatic wait_rvalid(output int cycles, output logic [31:0] data);
        cycles = -1; data = '0;
        for (int k = 1; k <= 20; k++) begin
            idle();
            if (o_rv) begin
                cycles = k;
                data = o_rdata;
                return;
            end
        end
        check("rvalid_timeout", {31'b0, o_rv}, 32'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 64 && q.size() != 0; k++) idle();
        idle();
    endtask

    initial begin
        int          lat;
        logic        rvg;
        int          cycles;
        logic [31:0] data;
        int          rv_seen;
        logic [31:0] r32;
        logic [3:0]  ridx;
        logic [2:0]  gd;

        n_cmp = 0; n_mis = 0; cyc = 0; in_req = 1'b0; req_start = 0; req_lat = 0;
        rst_i = 1'b1; req_i = 1'b1; addr_i = '0; we_i = 1'b0; be_i = '0; wdata_i = '0;
        gnt_delay_i = '0; rv_delay_i = '0;
        @(posedge clk_i);
        #1;

        // Reset held with a request pending
        step(1'b1, 32'h10, 1'b0, 4'hF, 32'h0, 3'd0, 3'd0, 1'b1);
        step(1'b1, 32'h10, 1'b0, 4'hF, 32'h0, 3'd0, 3'd0, 1'b1);

        // Initialise the words the bench reads
        for (int i = 0; i < 16; i++) begin
            txn(32'(i * 4), 1'b1, 4'hF, $urandom(), 3'd0, 3'd0, 1'b0, lat, rvg);
        end
        txn(32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF, 3'd0, 3'd0, 1'b0, lat, rvg);
        txn(32'h20, 1'b1, 4'hF, 32'hAAAA_AAAA, 3'd0, 3'd0, 1'b0, lat, rvg);
        drain();

        // Zero-delay read
        txn(32'h10, 1'b0, 4'hF, 32'h0, 3'd0, 3'd0, 1'b0, lat, rvg);
        check("zero_gnt_lat", 32'(lat), 32'd0);
        wait_rvalid(cycles, data);
        check("zero_rv_lat", 32'(cycles), 32'd1);
        check("zero_rdata", data, 32'hDEAD_BEEF);
        drain();

        // Partial write then read-back
        txn(32'h20, 1'b1, 4'b0011, 32'h0000_1234, 3'd0, 3'd0, 1'b0, lat, rvg);
        txn(32'h20, 1'b0, 4'hF, 32'h0, 3'd0, 3'd0, 1'b0, lat, rvg);
        wait_rvalid(cycles, data);
        check("raw_rdata", data, 32'hAAAA_1234);
        drain();

        // Maximum delays clamp to 5
        txn(32'h10, 1'b0, 4'hF, 32'h0, 3'd7, 3'd7, 1'b0, lat, rvg);
        check("max_gnt_lat", 32'(lat), 32'd5);
        wait_rvalid(cycles, data);
        check("max_rv_lat", 32'(cycles), 32'd5);
        check("max_rdata", data, 32'hDEAD_BEEF);
        drain();

        // Full stall and same-cycle push/pop
        for (int i = 0; i < 4; i++) begin
            txn(32'(i * 4), 1'b0, 4'hF, 32'h0, 3'd0, 3'd5, 1'b0, lat, rvg);
            check("fill_gnt_lat", 32'(lat), 32'd0);
        end
        txn(32'h10, 1'b0, 4'hF, 32'h0, 3'd0, 3'd5, 1'b0, lat, rvg);
        check("full_gnt_lat", 32'(lat), 32'd1);
        check("full_rv_at_gnt", {31'b0, rvg}, 32'd1);
        idle();
        check("full_outstanding", {29'b0, o_out}, 32'd4);
        drain();

        // Reset with three requests in flight
        for (int i = 0; i < 3; i++) begin
            txn(32'(i * 4), 1'b0, 4'hF, 32'h0, 3'd0, 3'd5, 1'b0, lat, rvg);
        end
        step(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 3'd0, 3'd0, 1'b1);
        rv_seen = 0;
        for (int i = 0; i < 8; i++) begin
            idle();
            if (i == 0) check("rst_mid_outstanding", {29'b0, o_out}, 32'd0);
            if (o_rv) rv_seen++;
        end
        check("rst_mid_no_rvalid", 32'(rv_seen), 32'd0);

        // Randomised traffic against the reference model
        for (int n = 0; n < 200; n++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle();
            r32  = $urandom();
            ridx = 4'($urandom_range(0, 15));
            gd   = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
            txn({r32[31:10], 4'h0, ridx, r32[1:0]}, 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), $urandom(), gd, 3'($urandom_range(0, 7)), 1'b1,
                lat, rvg);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
